// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with Z/V/N flags and branch resolve.
// Define CTRL_WDOG_EN to add a 4-bit memory-wait watchdog that raises sticky err and halts.
module cpu_ctrl_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_instr,
  input  logic        i_imem_rdy,
  input  logic        i_dmem_rdy,
  input  logic        i_alu_z,
  input  logic        i_alu_v,
  input  logic        i_alu_n,
  output logic        o_imem_req,
  output logic        o_ir_en,
  output logic [3:0]  o_alu_op,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_rf_we,
  output logic        o_pc_en,
  output logic [1:0]  o_pc_sel,
  output logic [2:0]  o_flags,
  output logic        o_halted,
  output logic        o_err
);
  typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t      r_state;
  state_t      w_next;
  logic [15:9] r_ir;
  logic [2:0]  r_flags;
  logic [3:0]  w_op;
  logic [7:0]  w_cond;
  logic        w_taken, w_br, w_mem, w_sw, w_flag_all, w_flag_z, w_to;
  logic        w_unused;
  assign w_unused = &{1'b0, i_instr[8:0]};
  assign w_op = r_ir[15:12];
  assign w_br = (w_op == 4'hC) || (w_op == 4'hD);
  assign w_mem = (w_op == 4'h8) || (w_op == 4'h9);
  assign w_sw = (w_op == 4'h9);
  assign w_flag_all = (r_state == EXEC) && (w_op <= 4'h1);
  assign w_flag_z = (r_state == EXEC) && (w_op inside {4'h2, 4'h4, 4'h5, 4'h6});
  // Condition table indexed by IR[11:9]; flags are {Z,V,N} from the register, never the live ALU.
  assign w_cond = {1'b1, r_flags[1], r_flags[0] | r_flags[2], r_flags[2] | ~r_flags[0],
                   r_flags[0], ~r_flags[2] & ~r_flags[0], r_flags[2], ~r_flags[2]};
  assign w_taken = w_cond[r_ir[11:9]];
  assign o_imem_req = (r_state == FETCH);
  assign o_ir_en = (r_state == FETCH) && i_imem_rdy;
  assign o_alu_op = w_op;
  assign o_dmem_req = (r_state == MEM);
  assign o_dmem_we = (r_state == MEM) && w_sw;
  assign o_rf_we = (r_state == WB);
  assign o_pc_en = (r_state == WB) || ((r_state == EXEC) && w_br) || ((r_state == MEM) && w_sw && i_dmem_rdy);
  assign o_pc_sel = ((r_state == EXEC) && w_br && w_taken) ? ((w_op == 4'hC) ? 2'b01 : 2'b10) : 2'b00;
  assign o_flags = r_flags;
  assign o_halted = (r_state == HALT);
  always_comb begin
    w_next = (r_state == BOOT)                ? FETCH :
             (r_state == FETCH)               ? (i_imem_rdy ? DECODE : FETCH) :
             (r_state == DECODE)              ? ((w_op == 4'hF) ? HALT : EXEC) :
             (r_state == EXEC)                ? (w_mem ? MEM : (w_br ? FETCH : WB)) :
             (r_state == MEM)                 ? (i_dmem_rdy ? (w_sw ? FETCH : WB) : MEM) :
             (r_state == WB)                  ? FETCH : HALT;
  end
`ifdef CTRL_WDOG_EN
  logic [3:0] r_wcnt;
  logic       r_err;
  logic       w_wait;
  assign w_wait = ((r_state == FETCH) && !i_imem_rdy) || ((r_state == MEM) && !i_dmem_rdy);
  assign w_to = w_wait && (r_wcnt == 4'hF);
  assign o_err = r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_wcnt <= w_wait ? r_wcnt + 4'd1 : 4'd0;
      if (w_to) r_err <= 1'b1;
    end
  end
`else
  assign w_to = 1'b0;
  assign o_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_ir <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_to ? HALT : w_next;
      if (o_ir_en) r_ir <= i_instr[15:9];
      if (w_flag_all) r_flags <= {i_alu_z, i_alu_v, i_alu_n};
      else if (w_flag_z) r_flags[2] <= i_alu_z;
    end
  end
endmodule
